// File: rtl/tea_pkg.sv
// Shared TEA definitions used by both the encrypt and decrypt stages.
package tea_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       TEA_DELTA          = 32'h9E3779B9;
    localparam int unsigned TEA_ROUNDS_DEFAULT = 32;
    localparam word_t       TEA_SUM_INIT       = 32'hC6EF3720;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_t;

    // TEA mixing function: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb)
    function automatic word_t tea_mix(input word_t v, input word_t sum,
                                      input word_t ka, input word_t kb);
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption round (z is updated first, y uses the new z).
module tea_dec_round
    import tea_pkg::*;
(
    input  word_t y,
    input  word_t z,
    input  word_t sum,
    input  word_t k0,
    input  word_t k1,
    input  word_t k2,
    input  word_t k3,
    output word_t y_next,
    output word_t z_next
);

    // Inverse Feistel step; all arithmetic wraps mod 2^32
    always_comb begin
        z_next = z - tea_mix(y, sum, k2, k3);
        y_next = y - tea_mix(z_next, sum, k0, k1);
    end

endmodule

// File: rtl/tea_decrypt.sv
// Iterative TEA decryption core with valid/ready handshakes.
// Optional build macro TEA_DEC_UNROLL2_EN: two chained rounds per clock
// (ROUNDS must then be even), halving latency with bit-identical results.
module tea_decrypt
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = TEA_ROUNDS_DEFAULT,
    parameter word_t       DELTA  = TEA_DELTA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] v1_enc,
    input  logic [31:0] v2_enc,
    input  logic [31:0] key1,
    input  logic [31:0] key2,
    input  logic [31:0] key3,
    input  logic [31:0] key4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] v1_dec,
    output logic [31:0] v2_dec,
    output logic        busy
);

    if (ROUNDS == 0) begin : g_bad_rounds
        $error("tea_decrypt: ROUNDS must be >= 1");
    end

    localparam word_t SUM_INIT = word_t'(DELTA * ROUNDS);

    tea_state_t state, state_nx;
    logic       accept;
    logic       last;

    word_t y, z, sum, cnt;
    word_t k0, k1, k2, k3;
    word_t y_nx, z_nx;

`ifdef TEA_DEC_UNROLL2_EN
    if (ROUNDS % 2 != 0) begin : g_odd_rounds
        $error("tea_decrypt: ROUNDS must be even when TEA_DEC_UNROLL2_EN is set");
    end

    localparam word_t CNT_LOAD = word_t'(ROUNDS / 2 - 1);
    localparam word_t SUM_STEP = DELTA << 1;

    word_t y_mid, z_mid;

    // Second round runs with the sum value the following single round would see
    tea_dec_round u_round0 (
        .y(y), .z(z), .sum(sum),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3),
        .y_next(y_mid), .z_next(z_mid)
    );
    tea_dec_round u_round1 (
        .y(y_mid), .z(z_mid), .sum(sum - DELTA),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3),
        .y_next(y_nx), .z_next(z_nx)
    );
`else
    localparam word_t CNT_LOAD = word_t'(ROUNDS - 1);
    localparam word_t SUM_STEP = DELTA;

    tea_dec_round u_round0 (
        .y(y), .z(z), .sum(sum),
        .k0(k0), .k1(k1), .k2(k2), .k3(k3),
        .y_next(y_nx), .z_next(z_nx)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last      = (cnt == '0);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Block capture, round iteration and result load
    always_ff @(posedge clk) begin
        if (reset) begin
            y      <= '0;
            z      <= '0;
            sum    <= '0;
            cnt    <= '0;
            k0     <= '0;
            k1     <= '0;
            k2     <= '0;
            k3     <= '0;
            v1_dec <= '0;
            v2_dec <= '0;
        end else if (accept) begin
            y   <= v1_enc;
            z   <= v2_enc;
            k0  <= key1;
            k1  <= key2;
            k2  <= key3;
            k3  <= key4;
            sum <= SUM_INIT;
            cnt <= CNT_LOAD;
        end else if (state == RUN) begin
            y   <= y_nx;
            z   <= z_nx;
            sum <= sum - SUM_STEP;
            cnt <= cnt - 1'b1;
            if (last) begin
                v1_dec <= y_nx;
                v2_dec <= z_nx;
            end
        end
    end

endmodule

// File: tb/tb_tea_decrypt.sv
// Self-checking bench for tea_decrypt: plaintexts are encrypted by a
// reference TEA encryptor and must come back unchanged from the DUT.
module tb_tea_decrypt;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
`ifdef TEA_DEC_UNROLL2_EN
    localparam int unsigned LAT = ROUNDS / 2;
`else
    localparam int unsigned LAT = ROUNDS;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] v1_enc, v2_enc;
    logic [31:0] key1, key2, key3, key4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] v1_dec, v2_dec;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    tea_decrypt #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .v1_enc(v1_enc), .v2_enc(v2_enc),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .out_valid(out_valid), .out_ready(out_ready),
        .v1_dec(v1_dec), .v2_dec(v2_dec),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference TEA encryption (forward direction, sum counts up from 0)
    function automatic logic [63:0] tea_enc_model(input logic [31:0] p0, input logic [31:0] p1,
                                                  input logic [127:0] key);
        logic [31:0] k[4];
        logic [31:0] y, z, sum;
        k[0] = key[127:96];
        k[1] = key[95:64];
        k[2] = key[63:32];
        k[3] = key[31:0];
        y = p0;
        z = p1;
        sum = 32'd0;
        for (int i = 0; i < int'(ROUNDS); i++) begin
            sum = sum + DELTA;
            y = y + (((z << 4) + k[0]) ^ (z + sum) ^ ((z >> 5) + k[1]));
            z = z + (((y << 4) + k[2]) ^ (y + sum) ^ ((y >> 5) + k[3]));
        end
        return {y, z};
    endfunction

    task automatic drive_random_inputs();
        in_valid = 1'($urandom);
        v1_enc   = $urandom;
        v2_enc   = $urandom;
        key1     = $urandom;
        key2     = $urandom;
        key3     = $urandom;
        key4     = $urandom;
    endtask

    // Send one block, wait for the result, check latency/data, then release it.
    task automatic run_block(input string tag, input logic [31:0] c0, input logic [31:0] c1,
                             input logic [127:0] key, input logic [63:0] exp,
                             input bit churn, input int unsigned hold);
        int unsigned k;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        v1_enc    = c0;
        v2_enc    = c1;
        {key1, key2, key3, key4} = key;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".busy_run"}, 64'(busy), 64'd1);
        check({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        k = 0;
        while (!out_valid && k < LAT + 20) begin
            if (churn) drive_random_inputs();
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 64'(k), 64'(LAT));
        check({tag, ".result"}, {v1_dec, v2_dec}, exp);
        if (hold > 0) begin
            for (int i = 0; i < int'(hold); i++) begin
                in_valid = 1'b1;
                v1_enc   = $urandom;
                v2_enc   = $urandom;
                @(negedge clk);
                check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, ".hold_data"}, {v1_dec, v2_dec}, exp);
            end
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
        check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, ".busy_after"}, 64'(busy), 64'd0);
        check({tag, ".data_kept"}, {v1_dec, v2_dec}, exp);
    endtask

    initial begin
        logic [127:0] key;
        logic [63:0]  pt, ct;
        bit           saw_valid;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        v1_enc    = '0;
        v2_enc    = '0;
        key1      = '0;
        key2      = '0;
        key3      = '0;
        key4      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.data", {v1_dec, v2_dec}, 64'd0);

        // Known zero-key vector
        run_block("zero", 32'h41EA3A0A, 32'h94BAA940, 128'd0, 64'd0, 1'b0, 0);

        // Loopback through the reference encryptor
        key = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        pt  = {32'h12345678, 32'h9ABCDEF0};
        ct  = tea_enc_model(pt[63:32], pt[31:0], key);
        run_block("loop", ct[63:32], ct[31:0], key, pt, 1'b0, 0);

        // Backpressure: hold out_ready low for 10 cycles
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom};
        ct  = tea_enc_model(pt[63:32], pt[31:0], key);
        run_block("bp", ct[63:32], ct[31:0], key, pt, 1'b0, 10);

        // Random blocks with input churn during RUN
        for (int i = 0; i < 4; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom};
            ct  = tea_enc_model(pt[63:32], pt[31:0], key);
            run_block("churn", ct[63:32], ct[31:0], key, pt, 1'b1, 0);
        end

        // Reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        v1_enc   = 32'h41EA3A0A;
        v2_enc   = 32'h94BAA940;
        {key1, key2, key3, key4} = 128'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT / 2 - 1) @(negedge clk);
        check("midrun.busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun.in_ready", 64'(in_ready), 64'd1);
        check("midrun.busy_clr", 64'(busy), 64'd0);
        check("midrun.data_clr", {v1_dec, v2_dec}, 64'd0);
        saw_valid = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrun.no_output", 64'(saw_valid), 64'd0);
        run_block("zero_after_reset", 32'h41EA3A0A, 32'h94BAA940, 128'd0, 64'd0, 1'b0, 0);

        // Reset and in_valid on the same edge: nothing captured
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid.busy", 64'(busy), 64'd0);
        check("rst_vs_valid.in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("rst_vs_valid.still_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
